// File: rtl/hdlc_pkg.sv
// hdlc_pkg: state type and framing constants shared by
// the HDLC bit-stuffing transmitter.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN_FLAG,
    DATA,
    STUFF,
    CLOSE_FLAG,
    ABORT
  } tx_state_t;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam int         ABORT_LEN = 7;
  localparam int         FLAG_LEN  = 8;

endpackage

// File: rtl/hdlc_bit_stuffer.sv
// hdlc_bit_stuffer: ones-run counter that forces a 0 after
// ONES_LIMIT consecutive data 1s.
module hdlc_bit_stuffer #(
  parameter int ONES_LIMIT = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic advance_i,
  input  logic clear_i,
  output logic line_o,
  output logic stuffed_o,
  output logic hold_o
);

  localparam int CW = $clog2(ONES_LIMIT + 1);
  localparam logic [CW-1:0] LIM   = CW'(ONES_LIMIT);
  localparam logic [CW-1:0] LIM_M = CW'(ONES_LIMIT - 1);

  logic [CW-1:0] ones_q, ones_d;
  logic          stuff_now;

  // A saturated counter means this cycle carries the stuffed 0.
  assign stuff_now = (ones_q == LIM);
  assign line_o    = raw_i & ~stuff_now;
  assign stuffed_o = stuff_now;
  assign hold_o    = advance_i & raw_i & ~stuff_now
                   & (ones_q == LIM_M);

  always_comb begin
    ones_d = ones_q;
    if (clear_i) begin
      ones_d = '0;
    end else if (advance_i) begin
      if (stuff_now || !raw_i) begin
        ones_d = '0;
      end else if (ones_q != LIM) begin
        ones_d = ones_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hdlc_bit_stuff_tx.sv
// hdlc_bit_stuff_tx: flag-delimited, bit-stuffed serial framer.
// HDLC_TX_IDLE_FLAG_EN: send back-to-back flags while idle.
module hdlc_bit_stuff_tx
  import hdlc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ONES_LIMIT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  input  logic              last,
  output logic              ready,
  output logic              ser_out,
  output logic              stuffed,
  output logic              abort,
  output logic              busy
);

  localparam int IW = $clog2(DATA_W);
  localparam int CW = $clog2(FLAG_LEN);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);
  localparam logic [CW-1:0] FLAG_END  = CW'(FLAG_LEN - 1);
  localparam logic [CW-1:0] ABORT_END = CW'(ABORT_LEN - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic              ser_q, ser_d;
  logic              stf_q, stf_d;
  logic              abt_q, abt_d;
  logic              rdy, adv, clr, slot;
  logic              st_line, st_stuffed, st_hold;

  hdlc_bit_stuffer #(
    .ONES_LIMIT(ONES_LIMIT)
  ) u_stuffer (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (byte_q[bit_idx_q]),
    .advance_i(adv),
    .clear_i  (clr),
    .line_o   (st_line),
    .stuffed_o(st_stuffed),
    .hold_o   (st_hold)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    last_d    = last_q;
    rdy       = 1'b0;
    ser_d     = 1'b1;
    stf_d     = 1'b0;
    abt_d     = 1'b0;
    adv       = 1'b0;
    clr       = 1'b0;
    slot      = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef HDLC_TX_IDLE_FLAG_EN
        ser_d = FLAG_BYTE[cnt_q];
        rdy   = (cnt_q == FLAG_END);
        cnt_d = cnt_q + 1'b1;
        if (valid && rdy) begin
          clr       = 1'b1;
          bit_idx_d = '0;
          state_d   = DATA;
        end
`else
        rdy = 1'b1;
        if (valid) begin
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = OPEN_FLAG;
        end
`endif
      end
      OPEN_FLAG: begin
        ser_d = FLAG_BYTE[cnt_q];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FLAG_END) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        adv   = 1'b1;
        ser_d = st_line;
        if (st_hold) begin
          state_d = STUFF;
        end else if (bit_idx_q == LAST_IDX) begin
          slot = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STUFF: begin
        adv   = 1'b1;
        ser_d = st_line;
        stf_d = st_stuffed;
        if (bit_idx_q == LAST_IDX) begin
          slot = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = DATA;
        end
      end
      CLOSE_FLAG: begin
        ser_d = FLAG_BYTE[cnt_q];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FLAG_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      ABORT: begin
        abt_d = (cnt_q == '0);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ABORT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Storage frees next cycle: close, chain or abort.
    if (slot) begin
      if (last_q) begin
        cnt_d   = '0;
        state_d = CLOSE_FLAG;
      end else begin
        rdy = 1'b1;
        if (valid) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d   = '0;
          state_d = ABORT;
        end
      end
    end
    if (valid && rdy) begin
      byte_d = data_in;
      last_d = last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      ser_q     <= 1'b1;
      stf_q     <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      ser_q     <= ser_d;
      stf_q     <= stf_d;
      abt_q     <= abt_d;
    end
  end

  assign ready   = rdy;
  assign ser_out = ser_q;
  assign stuffed = stf_q;
  assign abort   = abt_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_hdlc_bit_stuff_tx.sv
// tb_hdlc_bit_stuff_tx: directed frames with hand-written
// expected line streams for hdlc_bit_stuff_tx.
module tb_hdlc_bit_stuff_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid;
  logic       last;
  logic       ready;
  logic       ser_out;
  logic       stuffed;
  logic       abort;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [127:0] cap_ser, cap_stf, cap_abt, cap_busy, cap_rdy;
  logic [127:0] es, ef, ea, m;
  logic [7:0]   tx_b [0:3];
  logic         tx_l [0:3];
  int           n_tx, k;
  string        FL = "01111110";

  hdlc_bit_stuff_tx #(.DATA_W(8), .ONES_LIMIT(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .valid  (valid),
    .last   (last),
    .ready  (ready),
    .ser_out(ser_out),
    .stuffed(stuffed),
    .abort  (abort),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Index i: state cycle i (ready/busy) and the bit it puts on ser_out.
  task automatic run(input int n);
    logic acc;
    cap_ser = '0; cap_stf = '0; cap_abt = '0;
    cap_busy = '0; cap_rdy = '0;
    for (int i = 0; i < n; i++) begin
      if (k < n_tx) begin
        valid = 1'b1; data_in = tx_b[k]; last = tx_l[k];
      end else begin
        valid = 1'b0; data_in = 8'h00; last = 1'b0;
      end
      #1;
      cap_rdy[i]  = ready;
      cap_busy[i] = busy;
      acc = valid && ready;
      @(posedge clk);
      #1;
      cap_ser[i] = ser_out;
      cap_stf[i] = stuffed;
      cap_abt[i] = abort;
      if (acc) k++;
    end
    valid = 1'b0;
  endtask

  // '1','0' data/flag bits; 's' stuffed 0; 'a' abort-marked 1.
  task automatic decode(input string s);
    es = '0; ef = '0; ea = '0; m = '0;
    for (int j = 0; j < s.len(); j++) begin
      m[j]  = 1'b1;
      es[j] = (s[j] == "1") || (s[j] == "a");
      ef[j] = (s[j] == "s");
      ea[j] = (s[j] == "a");
    end
  endtask

  task automatic load1(input logic [7:0] b, input logic l);
    tx_b[0] = b; tx_l[0] = l; n_tx = 1; k = 0;
  endtask

  task automatic test_reset;
    tests++;
    if (ser_out !== 1'b1 || stuffed !== 1'b0 ||
        abort !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset ser/stf/abt/busy got %b%b%b%b want 1000",
               ser_out, stuffed, abort, busy);
    end
    tests++;
`ifdef HDLC_TX_IDLE_FLAG_EN
    if (ready !== 1'b0) begin
`else
    if (ready !== 1'b1) begin
`endif
      fails++;
      $display("FAIL reset_ready got %b", ready);
    end
  endtask

  task automatic test_single_3e;
    load1(8'h3E, 1'b1);
    run(28);
    decode({"1", FL, "011111s00", FL, "1"});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL 3e_ser got %h want %h", cap_ser & m, es);
    end
    tests++;
    if ((cap_stf & m) !== ef) begin
      fails++; $display("FAIL 3e_stuffed got %h want %h", cap_stf & m, ef);
    end
    tests++;
    if (cap_busy[27:0] !== 28'h3FFFFFE) begin
      fails++; $display("FAIL 3e_busy got %h want 3fffffe", cap_busy[27:0]);
    end
    tests++;
    if (cap_rdy[27:0] !== 28'hC000001) begin
      fails++; $display("FAIL 3e_ready got %h want c000001", cap_rdy[27:0]);
    end
  endtask

  task automatic test_ff;
    load1(8'hFF, 1'b1);
    run(28);
    decode({"1", FL, "11111s111", FL, "1"});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL ff_ser got %h want %h", cap_ser & m, es);
    end
    tests++;
    if ((cap_stf & m) !== ef) begin
      fails++; $display("FAIL ff_stuffed got %h want %h", cap_stf & m, ef);
    end
    tests++;
    if ($countones(cap_stf) != 1) begin
      fails++; $display("FAIL ff_stuff_count got %0d want 1", $countones(cap_stf));
    end
  endtask

  task automatic test_back_to_back;
    tx_b[0] = 8'hFF; tx_l[0] = 1'b0;
    tx_b[1] = 8'hFF; tx_l[1] = 1'b1;
    n_tx = 2; k = 0;
    run(38);
    decode({"1", FL, "11111s111", "11s11111s1", FL, "1"});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL b2b_ser got %h want %h", cap_ser & m, es);
    end
    tests++;
    if ((cap_stf & m) !== ef) begin
      fails++; $display("FAIL b2b_stuffed got %h want %h", cap_stf & m, ef);
    end
    tests++;
    if ($countones(cap_stf) != 3) begin
      fails++; $display("FAIL b2b_stuff_count got %0d want 3", $countones(cap_stf));
    end
    tests++;
    if (cap_rdy[17] !== 1'b1 || k != 2) begin
      fails++; $display("FAIL b2b_chain ready=%b accepted=%0d want 1 and 2", cap_rdy[17], k);
    end
  endtask

  task automatic test_underrun;
    load1(8'h01, 1'b0);
    run(25);
    decode({"1", FL, "10000000", "a111111", "1"});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL ur_ser got %h want %h", cap_ser & m, es);
    end
    tests++;
    if ((cap_abt & m) !== ea) begin
      fails++; $display("FAIL ur_abort got %h want %h", cap_abt & m, ea);
    end
    tests++;
    if (cap_rdy[24:0] !== 25'h1010001) begin
      fails++; $display("FAIL ur_ready got %h want 1010001", cap_rdy[24:0]);
    end
    tests++;
    if (cap_busy[24:0] !== 25'h0FFFFFE) begin
      fails++; $display("FAIL ur_busy got %h want 0fffffe", cap_busy[24:0]);
    end
  endtask

  task automatic test_reset_mid;
    load1(8'hA5, 1'b1);
    run(12);
    decode({"1", FL, "101"});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL rm_pre_ser got %h want %h", cap_ser & m, es);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ser_out !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rm_async ser/rdy/busy got %b%b%b want 110", ser_out, ready, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (ser_out !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rm_hold ser/busy got %b%b want 10", ser_out, busy);
    end
    load1(8'h00, 1'b1);
    run(27);
    decode({"1", FL, "00000000", FL, "1"});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL rm_frame_ser got %h want %h", cap_ser & m, es);
    end
    tests++;
    if ((cap_stf | cap_abt) !== '0) begin
      fails++; $display("FAIL rm_frame_flags got %h want 0", cap_stf | cap_abt);
    end
  endtask

  task automatic test_idle_flag;
    load1(8'hFF, 1'b1);
    run(40);
    decode({FL, "11111s111", FL, FL});
    tests++;
    if ((cap_ser & m) !== es) begin
      fails++; $display("FAIL if_ser got %h want %h", cap_ser & m, es);
    end
    tests++;
    if ((cap_stf & m) !== ef) begin
      fails++; $display("FAIL if_stuffed got %h want %h", cap_stf & m, ef);
    end
    tests++;
    if (cap_rdy[39:0] !== 40'h0100000080) begin
      fails++; $display("FAIL if_ready got %h want 0100000080", cap_rdy[39:0]);
    end
    tests++;
    if (cap_busy[39:0] !== 40'h0001FFFF00) begin
      fails++; $display("FAIL if_busy got %h want 0001ffff00", cap_busy[39:0]);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data_in = 8'h00; last = 1'b0;
    n_tx = 0; k = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
`ifdef HDLC_TX_IDLE_FLAG_EN
    test_idle_flag();
`else
    test_single_3e();
    test_ff();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
